mem_sequencer: RTL and testbench



---
 rtl/mem_seq_pkg.sv | 32 +++
 rtl/mem_sequencer_alu.sv | 42 ++++
 rtl/mem_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_mem_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
// Purpose: shared opcode and state definitions for mem_sequencer and its ALU.
// Ports: none (package).
package mem_seq_pkg;

  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
  localparam logic [OPC_W-1:0] OP_STA = 4'h2;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h3;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h4;
  localparam logic [OPC_W-1:0] OP_JMP = 4'h5;
  localparam logic [OPC_W-1:0] OP_JZ  = 4'h6;
  localparam logic [OPC_W-1:0] OP_HLT = 4'h7;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH_OP  = 3'd1,
    ST_WAIT_OP   = 3'd2,
    ST_FETCH_ARG = 3'd3,
    ST_WAIT_ARG  = 3'd4,
    ST_EXEC      = 3'd5,
    ST_MEM_WAIT  = 3'd6,
    ST_HALT      = 3'd7
  } state_t;

  // Opcodes that read their operand from memory and finish in MEM_WAIT.
  function automatic logic is_mem_read_op(input logic [OPC_W-1:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/mem_sequencer_alu.sv
// Purpose: combinational accumulator ALU for LDA/ADD/SUB.
// Ports: a (accumulator), b (memory operand), op (opcode) ->
//        result, zero (result == 0), carry (ADD carry-out / SUB borrow).
module seq_alu
  import mem_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OPC_W-1:0]  op,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;

  // Extra top bit gives the carry-out of ADD and the borrow of SUB.
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  // LDA (and anything else) passes the operand through with carry cleared.
  always_comb begin
    result = b;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = w_sum[DATA_W-1:0];
        carry  = w_sum[DATA_W];
      end
      OP_SUB: begin
        result = w_diff[DATA_W-1:0];
        carry  = w_diff[DATA_W];
      end
      default: ;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/mem_sequencer.sv
// Purpose: fetch/execute controller driving a shared 256-byte Memory.
//          Fetches two-byte instructions (opcode, operand address) and runs
//          them against an accumulator with zero/carry flags until HLT.
// Ports:
//   power, reset          clock (rising edge), async active-high reset
//   run_en                permits leaving IDLE / continuing at a boundary
//   data_out, ir_out      Memory read data / opcode-fetch data
//   add, data_in          Memory address / write data (always the accumulator)
//   read, write, ir_en    Memory strobes; ir_en marks an opcode fetch
//   pc_out, acc_out       program counter / accumulator
//   zero_flag, carry_flag flags from the last LDA/ADD/SUB
//   halted                high once HLT has executed
module mem_sequencer
  import mem_seq_pkg::*;
#(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              power,
  input  logic              reset,
  input  logic              run_en,
  input  logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] ir_out,
  output logic [ADDR_W-1:0] add,
  output logic [DATA_W-1:0] data_in,
  output logic              read,
  output logic              write,
  output logic              ir_en,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] acc_out,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              halted
);

  state_t              r_state,  w_state_nxt;
  logic [ADDR_W-1:0]   r_pc,     w_pc_nxt;
  logic [DATA_W-1:0]   r_ir,     w_ir_nxt;
  logic [ADDR_W-1:0]   r_arg,    w_arg_nxt;
  logic [DATA_W-1:0]   r_acc,    w_acc_nxt;
  logic                r_zero,   w_zero_nxt;
  logic                r_carry,  w_carry_nxt;
  logic [ADDR_W-1:0]   r_add,    w_add_nxt;
  logic                r_read,   w_read_nxt;
  logic                r_write,  w_write_nxt;
  logic                r_ir_en,  w_ir_en_nxt;
  logic                r_halted, w_halted_nxt;

  logic [OPC_W-1:0]    w_op;
  logic [DATA_W-1:0]   w_alu_result;
  logic                w_alu_zero;
  logic                w_alu_carry;
  state_t              w_boundary;
  logic                w_unused_ir;

  assign w_op        = r_ir[DATA_W-1 -: OPC_W];
  // Low opcode-byte bits carry no meaning.
  assign w_unused_ir = ^r_ir[DATA_W-OPC_W-1:0];

  seq_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (r_acc),
    .b      (data_out),
    .op     (w_op),
    .result (w_alu_result),
    .zero   (w_alu_zero),
    .carry  (w_alu_carry)
  );

  // State, datapath and registered memory-control outputs.
  always_ff @(posedge power or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_arg    <= '0;
      r_acc    <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_add    <= '0;
      r_read   <= 1'b0;
      r_write  <= 1'b0;
      r_ir_en  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_ir     <= w_ir_nxt;
      r_arg    <= w_arg_nxt;
      r_acc    <= w_acc_nxt;
      r_zero   <= w_zero_nxt;
      r_carry  <= w_carry_nxt;
      r_add    <= w_add_nxt;
      r_read   <= w_read_nxt;
      r_write  <= w_write_nxt;
      r_ir_en  <= w_ir_en_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  // Next state/datapath, then Moore outputs decoded from the next state so
  // the registered strobes line up with the state they belong to.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_ir_nxt     = r_ir;
    w_arg_nxt    = r_arg;
    w_acc_nxt    = r_acc;
    w_zero_nxt   = r_zero;
    w_carry_nxt  = r_carry;
    w_add_nxt    = '0;
    w_read_nxt   = 1'b0;
    w_write_nxt  = 1'b0;
    w_ir_en_nxt  = 1'b0;
    w_halted_nxt = 1'b0;
    w_boundary   = run_en ? ST_FETCH_OP : ST_IDLE;

    case (r_state)
      ST_IDLE: begin
        if (run_en) w_state_nxt = ST_FETCH_OP;
      end
      ST_FETCH_OP:  w_state_nxt = ST_WAIT_OP;
      ST_WAIT_OP: begin
        w_ir_nxt    = ir_out;
        w_pc_nxt    = r_pc + ADDR_W'(1);
        w_state_nxt = ST_FETCH_ARG;
      end
      ST_FETCH_ARG: w_state_nxt = ST_WAIT_ARG;
      ST_WAIT_ARG: begin
        w_arg_nxt   = ADDR_W'(data_out);
        w_pc_nxt    = r_pc + ADDR_W'(1);
        w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        w_state_nxt = w_boundary;
        if (is_mem_read_op(w_op)) begin
          w_state_nxt = ST_MEM_WAIT;
        end else if (w_op == OP_HLT) begin
          w_state_nxt = ST_HALT;
        end else if (w_op == OP_JMP) begin
          w_pc_nxt = r_arg;
        end else if ((w_op == OP_JZ) && r_zero) begin
          w_pc_nxt = r_arg;
        end
      end
      ST_MEM_WAIT: begin
        w_acc_nxt   = w_alu_result;
        w_zero_nxt  = w_alu_zero;
        w_carry_nxt = w_alu_carry;
        w_state_nxt = w_boundary;
      end
      ST_HALT:      w_state_nxt = ST_HALT;
      default:      w_state_nxt = ST_IDLE;
    endcase

    case (w_state_nxt)
      ST_FETCH_OP: begin
        w_add_nxt   = w_pc_nxt;
        w_read_nxt  = 1'b1;
        w_ir_en_nxt = 1'b1;
      end
      ST_FETCH_ARG: begin
        w_add_nxt  = w_pc_nxt;
        w_read_nxt = 1'b1;
      end
      ST_EXEC: begin
        w_add_nxt   = w_arg_nxt;
        w_read_nxt  = is_mem_read_op(w_ir_nxt[DATA_W-1 -: OPC_W]);
        w_write_nxt = (w_ir_nxt[DATA_W-1 -: OPC_W] == OP_STA);
      end
      ST_HALT:     w_halted_nxt = 1'b1;
      default: ;
    endcase
  end

  assign add        = r_add;
  assign data_in    = r_acc;
  assign read       = r_read;
  assign write      = r_write;
  assign ir_en      = r_ir_en;
  assign pc_out     = r_pc;
  assign acc_out    = r_acc;
  assign zero_flag  = r_zero;
  assign carry_flag = r_carry;
  assign halted     = r_halted;

endmodule

// File: tb/tb_mem_sequencer.sv
module tb_mem_sequencer;

  typedef struct {
    logic [7:0] acc;
    logic       zero;
    logic       carry;
    logic [7:0] pc;
    logic       chk_mem;
    logic [7:0] m_addr;
    logic [7:0] m_val;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   overlap_cnt = 0;

  logic clk = 1'b0;
  logic rst0, rst1, run_en, use_w;
  logic clr, ld_en0, ld_en1;
  logic [7:0] ld_a, ld_d;

  logic [7:0] dout0, irout0, add0, din0, pc0, acc0;
  logic       rd0, wr0, iren0, z0, c0, h0;
  logic [7:0] dout1, irout1, add1, din1, pc1, acc1;
  logic       rd1, wr1, iren1, z1, c1, h1;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];

  always #5 clk = ~clk;

  mem_sequencer dut (
    .power(clk), .reset(rst0), .run_en(run_en), .data_out(dout0), .ir_out(irout0),
    .add(add0), .data_in(din0), .read(rd0), .write(wr0), .ir_en(iren0),
    .pc_out(pc0), .acc_out(acc0), .zero_flag(z0), .carry_flag(c0), .halted(h0)
  );

  mem_sequencer #(.RESET_PC(8'hFE)) dut_w (
    .power(clk), .reset(rst1), .run_en(run_en), .data_out(dout1), .ir_out(irout1),
    .add(add1), .data_in(din1), .read(rd1), .write(wr1), .ir_en(iren1),
    .pc_out(pc1), .acc_out(acc1), .zero_flag(z1), .carry_flag(c1), .halted(h1)
  );

  // Behavioural Memory: samples strobes on the rising edge, data valid after it.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) begin
        mem0[i] <= 8'h00;
        mem1[i] <= 8'h00;
      end
    end else begin
      if (ld_en0) mem0[ld_a] <= ld_d;
      if (ld_en1) mem1[ld_a] <= ld_d;
      if (wr0) mem0[add0] <= din0;
      if (rd0) begin
        if (iren0) irout0 <= mem0[add0];
        else       dout0  <= mem0[add0];
      end
      if (wr1) mem1[add1] <= din1;
      if (rd1) begin
        if (iren1) irout1 <= mem1[add1];
        else       dout1  <= mem1[add1];
      end
    end
  end

  logic       m_h, m_z, m_c, prev_h;
  logic [7:0] m_acc, m_pc, m_din;
  assign m_h   = use_w ? h1   : h0;
  assign m_z   = use_w ? z1   : z0;
  assign m_c   = use_w ? c1   : c0;
  assign m_acc = use_w ? acc1 : acc0;
  assign m_pc  = use_w ? pc1  : pc0;
  assign m_din = use_w ? din1 : din0;

  // Scoreboard: pop one expectation each time the active sequencer halts.
  initial prev_h = 1'b0;
  always @(negedge clk) begin
    if ((rd0 && wr0) || (rd1 && wr1)) overlap_cnt++;
    if (m_h && !prev_h) begin
      if (sb.size() == 0) begin
        tests_run++; tests_failed++;
        $display("FAIL sb_unexpected_halt: got halt at pc %h, required no halt", m_pc);
      end else begin
        e_mon = sb.pop_front();
        tests_run++;
        if (m_acc !== e_mon.acc) begin tests_failed++; $display("FAIL sb_acc: got %h required %h", m_acc, e_mon.acc); end
        tests_run++;
        if (m_din !== e_mon.acc) begin tests_failed++; $display("FAIL sb_data_in: got %h required %h", m_din, e_mon.acc); end
        tests_run++;
        if (m_z !== e_mon.zero) begin tests_failed++; $display("FAIL sb_zero: got %b required %b", m_z, e_mon.zero); end
        tests_run++;
        if (m_c !== e_mon.carry) begin tests_failed++; $display("FAIL sb_carry: got %b required %b", m_c, e_mon.carry); end
        tests_run++;
        if (m_pc !== e_mon.pc) begin tests_failed++; $display("FAIL sb_pc: got %h required %h", m_pc, e_mon.pc); end
        if (e_mon.chk_mem) begin
          tests_run++;
          if (mem0[e_mon.m_addr] !== e_mon.m_val) begin
            tests_failed++;
            $display("FAIL sb_mem[%h]: got %h required %h", e_mon.m_addr, mem0[e_mon.m_addr], e_mon.m_val);
          end
        end
      end
    end
    prev_h = m_h;
  end

  task automatic push_exp(input logic [7:0] acc, input logic z, input logic c, input logic [7:0] pc,
                          input logic chk, input logic [7:0] ma, input logic [7:0] mv);
    exp_t e;
    e.acc = acc; e.zero = z; e.carry = c; e.pc = pc; e.chk_mem = chk; e.m_addr = ma; e.m_val = mv;
    sb.push_back(e);
  endtask

  task automatic clear_mem();
    clr = 1'b1; @(negedge clk); clr = 1'b0;
  endtask

  task automatic load0(input logic [7:0] a, input logic [7:0] d);
    ld_en0 = 1'b1; ld_a = a; ld_d = d; @(negedge clk); ld_en0 = 1'b0;
  endtask

  task automatic load1(input logic [7:0] a, input logic [7:0] d);
    ld_en1 = 1'b1; ld_a = a; ld_d = d; @(negedge clk); ld_en1 = 1'b0;
  endtask

  task automatic load_prog0(input logic [63:0] p);
    for (int i = 0; i < 8; i++) load0(8'(i), p[63-8*i -: 8]);
  endtask

  task automatic reset0();
    rst0 = 1'b1; run_en = 1'b0; @(negedge clk);
  endtask

  // Release reset with run_en high; returns just after the edge into FETCH_OP.
  task automatic start0();
    run_en = 1'b1; rst0 = 1'b0; @(posedge clk); #1;
  endtask

  task automatic wait_halt(output int n);
    n = 0;
    while (m_h !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if ({add0, din0, rd0, wr0, iren0, h0} !== 20'h0) begin
      tests_failed++; $display("FAIL reset_strobes: got %h required 0", {add0, din0, rd0, wr0, iren0, h0});
    end
    tests_run++;
    if ({pc0, acc0, z0, c0} !== 18'h0) begin
      tests_failed++; $display("FAIL reset_regs: got %h required 0", {pc0, acc0, z0, c0});
    end
    tests_run++;
    if (pc1 !== 8'hFE) begin tests_failed++; $display("FAIL reset_pc_param: got %h required fe", pc1); end
  endtask

  task automatic test_basic();
    int n;
    reset0(); clear_mem();
    load_prog0(64'h1020_3021_2022_7000); load0(8'h20, 8'h05); load0(8'h21, 8'h07);
    push_exp(8'h0C, 1'b0, 1'b0, 8'h08, 1'b1, 8'h22, 8'h0C);
    start0();
    tests_run++;
    if ({add0, rd0, iren0, wr0} !== {8'h00, 3'b110}) begin
      tests_failed++; $display("FAIL basic_fetch_op: got %h/%b%b%b required 00/110", add0, rd0, iren0, wr0);
    end
    wait_halt(n);
    tests_run++;
    if (n !== 22) begin tests_failed++; $display("FAIL basic_halt_cycles: got %0d required 22", n); end
    @(negedge clk); #1;
  endtask

  task automatic test_add_carry();
    int n;
    reset0(); clear_mem();
    load_prog0(64'h1020_3021_2022_7000); load0(8'h20, 8'hF0); load0(8'h21, 8'h20);
    push_exp(8'h10, 1'b0, 1'b1, 8'h08, 1'b1, 8'h22, 8'h10);
    start0(); wait_halt(n);
    tests_run++;
    if (h0 !== 1'b1) begin tests_failed++; $display("FAIL add_carry_timeout: got halted %b required 1", h0); end
    @(negedge clk); #1;
  endtask

  task automatic test_jz_taken();
    int n;
    reset0(); clear_mem();
    load_prog0(64'h1020_4020_6040_7000); load0(8'h20, 8'h33);
    load0(8'h40, 8'h70); load0(8'h41, 8'h00);
    push_exp(8'h00, 1'b1, 1'b0, 8'h42, 1'b0, 8'h00, 8'h00);
    start0(); wait_halt(n);
    tests_run++;
    if (n !== 22) begin tests_failed++; $display("FAIL jz_taken_cycles: got %0d required 22", n); end
    @(negedge clk); #1;
  endtask

  task automatic test_jz_untaken();
    int n;
    reset0(); clear_mem();
    load_prog0(64'h1020_4021_6040_7000); load0(8'h20, 8'h05); load0(8'h21, 8'h07);
    load0(8'h40, 8'h70); load0(8'h41, 8'h00);
    push_exp(8'hFE, 1'b0, 1'b1, 8'h08, 1'b0, 8'h00, 8'h00);
    start0(); wait_halt(n);
    tests_run++;
    if (h0 !== 1'b1) begin tests_failed++; $display("FAIL jz_untaken_timeout: got halted %b required 1", h0); end
    @(negedge clk); #1;
  endtask

  task automatic test_undef_nop();
    int n;
    reset0(); clear_mem();
    load_prog0(64'h1020_9520_0000_7000);
    push_exp(8'h00, 1'b1, 1'b0, 8'h08, 1'b0, 8'h00, 8'h00);
    start0(); wait_halt(n);
    tests_run++;
    if (n !== 21) begin tests_failed++; $display("FAIL undef_nop_cycles: got %0d required 21", n); end
    @(negedge clk); #1;
  endtask

  task automatic test_run_en_gap();
    int n;
    reset0(); clear_mem();
    load_prog0(64'h1020_3021_2022_7000); load0(8'h20, 8'h05); load0(8'h21, 8'h07);
    push_exp(8'h0C, 1'b0, 1'b0, 8'h08, 1'b1, 8'h22, 8'h0C);
    start0();
    run_en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    tests_run++;
    if ({pc0, acc0, rd0, wr0, iren0} !== {8'h02, 8'h05, 3'b000}) begin
      tests_failed++; $display("FAIL run_en_park: got pc %h acc %h rwi %b%b%b required 02 05 000", pc0, acc0, rd0, wr0, iren0);
    end
    run_en = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({add0, rd0, iren0} !== {8'h02, 2'b11}) begin
      tests_failed++; $display("FAIL run_en_resume: got add %h rd %b ir_en %b required 02 1 1", add0, rd0, iren0);
    end
    wait_halt(n);
    @(negedge clk); #1;
  endtask

  task automatic test_reset_mid_sta();
    int n;
    reset0(); clear_mem();
    load_prog0(64'h1020_3021_2022_7000); load0(8'h20, 8'h05); load0(8'h21, 8'h07);
    start0();
    n = 0;
    while (wr0 !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (n !== 16) begin tests_failed++; $display("FAIL sta_exec_cycle: got %0d required 16", n); end
    #2 rst0 = 1'b1;
    #1;
    tests_run++;
    if ({wr0, rd0, add0, pc0, acc0} !== 26'h0) begin
      tests_failed++; $display("FAIL async_reset_abort: got wr %b rd %b add %h pc %h acc %h required all 0", wr0, rd0, add0, pc0, acc0);
    end
    @(negedge clk);
    tests_run++;
    if (mem0[8'h22] !== 8'h00) begin tests_failed++; $display("FAIL sta_aborted_mem: got %h required 00", mem0[8'h22]); end
    run_en = 1'b0; rst0 = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({rd0, wr0, iren0, h0, pc0} !== 12'h0) begin
      tests_failed++; $display("FAIL post_reset_idle: got rwih %b%b%b%b pc %h required 0000 00", rd0, wr0, iren0, h0, pc0);
    end
  endtask

  task automatic test_wrap();
    int n;
    reset0(); clear_mem();
    use_w = 1'b1;
    load1(8'hFE, 8'h50); load1(8'hFF, 8'h10); load1(8'h10, 8'h70); load1(8'h11, 8'h00);
    push_exp(8'h00, 1'b0, 1'b0, 8'h12, 1'b0, 8'h00, 8'h00);
    run_en = 1'b1; rst1 = 1'b0; @(posedge clk); #1;
    tests_run++;
    if ({add1, rd1, iren1} !== {8'hFE, 2'b11}) begin
      tests_failed++; $display("FAIL wrap_fetch_op: got add %h rd %b ir_en %b required fe 1 1", add1, rd1, iren1);
    end
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({add1, rd1, iren1, pc1} !== {8'hFF, 2'b10, 8'hFF}) begin
      tests_failed++; $display("FAIL wrap_fetch_arg: got add %h rd %b ir_en %b pc %h required ff 1 0 ff", add1, rd1, iren1, pc1);
    end
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (pc1 !== 8'h00) begin tests_failed++; $display("FAIL wrap_pc_ff_to_00: got %h required 00", pc1); end
    @(posedge clk); #1;
    tests_run++;
    if (pc1 !== 8'h10) begin tests_failed++; $display("FAIL wrap_jmp: got %h required 10", pc1); end
    wait_halt(n);
    @(negedge clk); #1;
    rst1 = 1'b1;
    @(negedge clk);
    use_w = 1'b0;
  endtask

  task automatic test_strobe_exclusive();
    tests_run++;
    if (overlap_cnt !== 0) begin
      tests_failed++; $display("FAIL read_write_overlap: got %0d cycles required 0", overlap_cnt);
    end
  endtask

  task automatic test_scoreboard_drain();
    tests_run++;
    if (sb.size() !== 0) begin
      tests_failed++; $display("FAIL sb_pending: got %0d expectations left required 0", sb.size());
    end
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; run_en = 1'b0; use_w = 1'b0;
    clr = 1'b0; ld_en0 = 1'b0; ld_en1 = 1'b0; ld_a = 8'h00; ld_d = 8'h00;
    test_reset();
    test_basic();
    test_add_carry();
    test_jz_taken();
    test_jz_untaken();
    test_undef_nop();
    test_run_en_gap();
    test_reset_mid_sta();
    test_wrap();
    test_strobe_exclusive();
    test_scoreboard_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
